// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS control unit and its datapath.
// The master side is the control unit: it receives the opcode and memory
// handshake and drives every datapath control line. The slave side is the
// datapath (or a testbench standing in for it).
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       MemReady;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] MemtoReg;
    logic [1:0] RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] State;
    logic       IllegalOp;
    logic       MemTimeout;

    modport master (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, State, IllegalOp, MemTimeout
    );

    modport slave (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, State, IllegalOp, MemTimeout
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multi-cycle MIPS datapath, with a sticky
// watchdog that flags a memory port which never raises MemReady.
// Define MULTICYCLE_CTRL_JAL_EN to add the JAL state (opcode 000011);
// without it, jal decodes as an illegal opcode.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    localparam int unsigned CNT_W =
        ($clog2(MEM_TIMEOUT + 1) < 4) ? 4 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
`ifdef MULTICYCLE_CTRL_JAL_EN
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11
`ifdef MULTICYCLE_CTRL_JAL_EN
        , JAL     = 4'd12
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             wait_state;

    // Next-state decode; the opcode is only consulted while the IR is stable.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     if (bus.MemReady) state_d = DECODE;
            DECODE: begin
                case (bus.Opcode)
                    OP_RTYPE:                          state_d = R_EXEC;
                    OP_LW, OP_SW:                      state_d = MEM_ADDR;
                    OP_BEQ:                            state_d = BRANCH;
                    OP_J:                              state_d = JUMP;
                    OP_ADDI, OP_ORI, OP_LUI, OP_ANDI:  state_d = I_EXEC;
`ifdef MULTICYCLE_CTRL_JAL_EN
                    OP_JAL:                            state_d = JAL;
`endif
                    default:                           state_d = FETCH;
                endcase
            end
            MEM_ADDR:  state_d = (bus.Opcode == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (bus.MemReady) state_d = MEM_WB;
            MEM_WRITE: if (bus.MemReady) state_d = FETCH;
            R_EXEC:    state_d = R_WB;
            I_EXEC:    state_d = I_WB;
            default:   state_d = FETCH;
        endcase
    end

    // Watchdog: count stalled cycles in memory states, latch the flag at the limit.
    always_comb begin
        wait_state = (state_q == FETCH) || (state_q == MEM_READ) ||
                     (state_q == MEM_WRITE);
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (bus.MemReady || (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else if (wait_state && (wait_cnt_q != CNT_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (wait_state && (wait_cnt_d == CNT_LIMIT)) begin
            timeout_d = 1'b1;
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Control outputs decoded from the current state; only IRWrite/PCWrite in FETCH look at MemReady.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 2'b00;
        bus.RegDst      = 2'b00;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 3'b000;
        bus.PCSource    = 2'b00;
        bus.State       = state_q;
        bus.IllegalOp   = 1'b0;
        bus.MemTimeout  = timeout_q;
        case (state_q)
            FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.MemReady;
                bus.PCWrite = bus.MemReady;
            end
            DECODE: begin
                bus.ALUSrcB   = 2'b11;
                bus.IllegalOp = (state_d == FETCH);
            end
            MEM_ADDR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUOp   = (bus.Opcode == OP_LW) ? 3'b101 : 3'b110;
            end
            MEM_READ: begin
                bus.IorD    = 1'b1;
                bus.MemRead = 1'b1;
            end
            MEM_WB: begin
                bus.MemtoReg = 2'b01;
                bus.RegWrite = 1'b1;
            end
            MEM_WRITE: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            R_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 3'b111;
            end
            R_WB: begin
                bus.RegDst   = 2'b01;
                bus.RegWrite = 1'b1;
            end
            I_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                case (bus.Opcode)
                    OP_ORI:  bus.ALUOp = 3'b001;
                    OP_LUI:  bus.ALUOp = 3'b010;
                    OP_ANDI: bus.ALUOp = 3'b011;
                    default: bus.ALUOp = 3'b000;
                endcase
            end
            I_WB: begin
                bus.RegWrite = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 3'b100;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
`ifdef MULTICYCLE_CTRL_JAL_EN
            JAL: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
                bus.RegDst   = 2'b10;
                bus.MemtoReg = 2'b10;
                bus.RegWrite = 1'b1;
            end
`endif
            default: begin
                bus.State = state_q;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks representative
// instructions through the FSM and checks state and control lines.
module tb_multicycle_control;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    multicycle_control_if bus ();

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive the opcode and memory handshake for the coming edges.
    task automatic apply_stimulus(input logic [5:0] opcode, input logic mem_ready);
        bus.Opcode   = opcode;
        bus.MemReady = mem_ready;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        apply_stimulus(6'b000000, 1'b0);
        #1;
        check_output("reset_state", bus.State, 8'd0);
        check_output("reset_memread", bus.MemRead, 8'd1);
        check_output("reset_alusrcb", bus.ALUSrcB, 8'd1);
        check_output("reset_aluop", bus.ALUOp, 8'd0);
        check_output("reset_irwrite", bus.IRWrite, 8'd0);
        check_output("reset_regwrite", bus.RegWrite, 8'd0);
        check_output("reset_timeout", bus.MemTimeout, 8'd0);
        check_output("reset_illegal", bus.IllegalOp, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // R-type add: 0,1,6,7,0
        apply_stimulus(6'b000000, 1'b1);
        #1;
        check_output("add_fetch_irwrite", bus.IRWrite, 8'd1);
        check_output("add_fetch_pcwrite", bus.PCWrite, 8'd1);
        tick();
        check_output("add_decode_state", bus.State, 8'd1);
        check_output("add_decode_alusrcb", bus.ALUSrcB, 8'd3);
        tick();
        check_output("add_exec_state", bus.State, 8'd6);
        check_output("add_exec_aluop", bus.ALUOp, 8'd7);
        check_output("add_exec_alusrca", bus.ALUSrcA, 8'd1);
        check_output("add_exec_regwrite", bus.RegWrite, 8'd0);
        tick();
        check_output("add_wb_state", bus.State, 8'd7);
        check_output("add_wb_regwrite", bus.RegWrite, 8'd1);
        check_output("add_wb_regdst", bus.RegDst, 8'd1);
        tick();
        check_output("add_done_state", bus.State, 8'd0);
        check_output("add_done_regwrite", bus.RegWrite, 8'd0);

        // lw with two wait cycles in MEM_READ: 0,1,2,3,3,3,4,0
        apply_stimulus(6'b100011, 1'b1);
        tick();
        check_output("lw_decode_state", bus.State, 8'd1);
        tick();
        check_output("lw_addr_state", bus.State, 8'd2);
        check_output("lw_addr_aluop", bus.ALUOp, 8'd5);
        check_output("lw_addr_alusrcb", bus.ALUSrcB, 8'd2);
        apply_stimulus(6'b100011, 1'b0);
        tick();
        check_output("lw_read_state", bus.State, 8'd3);
        check_output("lw_read_iord", bus.IorD, 8'd1);
        check_output("lw_read_memread", bus.MemRead, 8'd1);
        tick();
        check_output("lw_wait1_state", bus.State, 8'd3);
        tick();
        check_output("lw_wait2_state", bus.State, 8'd3);
        apply_stimulus(6'b100011, 1'b1);
        tick();
        check_output("lw_wb_state", bus.State, 8'd4);
        check_output("lw_wb_memtoreg", bus.MemtoReg, 8'd1);
        check_output("lw_wb_regwrite", bus.RegWrite, 8'd1);
        check_output("lw_wb_regdst", bus.RegDst, 8'd0);
        tick();
        check_output("lw_done_state", bus.State, 8'd0);

        // Illegal opcode 111111
        apply_stimulus(6'b111111, 1'b1);
        tick();
        check_output("ill_decode_state", bus.State, 8'd1);
        check_output("ill_pulse", bus.IllegalOp, 8'd1);
        check_output("ill_regwrite", bus.RegWrite, 8'd0);
        check_output("ill_memwrite", bus.MemWrite, 8'd0);
        check_output("ill_pcwrite", bus.PCWrite, 8'd0);
        tick();
        check_output("ill_return_state", bus.State, 8'd0);
        check_output("ill_pulse_end", bus.IllegalOp, 8'd0);

        // sw, then asynchronous reset while stalled in MEM_WRITE
        apply_stimulus(6'b101011, 1'b1);
        tick();
        tick();
        check_output("sw_addr_state", bus.State, 8'd2);
        check_output("sw_addr_aluop", bus.ALUOp, 8'd6);
        apply_stimulus(6'b101011, 1'b0);
        tick();
        check_output("sw_write_state", bus.State, 8'd5);
        check_output("sw_write_memwrite", bus.MemWrite, 8'd1);
        check_output("sw_write_iord", bus.IorD, 8'd1);
        tick();
        check_output("sw_wait_state", bus.State, 8'd5);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_state", bus.State, 8'd0);
        check_output("async_reset_memwrite", bus.MemWrite, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        // beq: 0,1,8,0
        apply_stimulus(6'b000100, 1'b1);
        tick();
        tick();
        check_output("beq_state", bus.State, 8'd8);
        check_output("beq_pcwritecond", bus.PCWriteCond, 8'd1);
        check_output("beq_pcsource", bus.PCSource, 8'd1);
        check_output("beq_aluop", bus.ALUOp, 8'd4);
        tick();
        check_output("beq_done_state", bus.State, 8'd0);

        // j: 0,1,9,0
        apply_stimulus(6'b000010, 1'b1);
        tick();
        tick();
        check_output("j_state", bus.State, 8'd9);
        check_output("j_pcwrite", bus.PCWrite, 8'd1);
        check_output("j_pcsource", bus.PCSource, 8'd2);
        tick();
        check_output("j_done_state", bus.State, 8'd0);

        // ori: 0,1,10,11,0
        apply_stimulus(6'b001101, 1'b1);
        tick();
        tick();
        check_output("ori_exec_state", bus.State, 8'd10);
        check_output("ori_exec_aluop", bus.ALUOp, 8'd1);
        check_output("ori_exec_alusrcb", bus.ALUSrcB, 8'd2);
        tick();
        check_output("ori_wb_state", bus.State, 8'd11);
        check_output("ori_wb_regwrite", bus.RegWrite, 8'd1);
        tick();
        check_output("ori_done_state", bus.State, 8'd0);

        // lui in I_EXEC
        apply_stimulus(6'b001111, 1'b1);
        tick();
        tick();
        check_output("lui_exec_aluop", bus.ALUOp, 8'd2);
        tick();
        tick();
        check_output("lui_done_state", bus.State, 8'd0);

        // jal
        apply_stimulus(6'b000011, 1'b1);
        tick();
        check_output("jal_decode_state", bus.State, 8'd1);
`ifdef MULTICYCLE_CTRL_JAL_EN
        check_output("jal_decode_illegal", bus.IllegalOp, 8'd0);
        tick();
        check_output("jal_state", bus.State, 8'd12);
        check_output("jal_regdst", bus.RegDst, 8'd2);
        check_output("jal_memtoreg", bus.MemtoReg, 8'd2);
        check_output("jal_regwrite", bus.RegWrite, 8'd1);
        check_output("jal_pcwrite", bus.PCWrite, 8'd1);
`else
        check_output("jal_decode_illegal", bus.IllegalOp, 8'd1);
`endif
        tick();
        check_output("jal_done_state", bus.State, 8'd0);

        // Watchdog: MemReady stuck low in FETCH
        apply_stimulus(6'b000000, 1'b0);
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        check_output("wd_before_limit", bus.MemTimeout, 8'd0);
        check_output("wd_still_fetch", bus.State, 8'd0);
        tick();
        check_output("wd_at_limit", bus.MemTimeout, 8'd1);
        tick();
        check_output("wd_keeps_waiting", bus.State, 8'd0);
        apply_stimulus(6'b000000, 1'b1);
        tick();
        check_output("wd_sticky_state", bus.State, 8'd1);
        check_output("wd_sticky_flag", bus.MemTimeout, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check_output("wd_cleared_by_reset", bus.MemTimeout, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
